// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers {pc, instr}, feeds decode.
// Latency: request accepted at N, response at N+k, out_valid at N+k+1 (no bypass).
// Backpressure: out_ready low fills the queue; credits (occupancy+live, live+drop) throttle requests.
module if_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     clr,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_resp_valid,
    input  logic [31:0]              imem_resp_data,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic                 r_clr_q;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    r_resp_pc;
    logic [CW-1:0]        r_live_cnt;
    logic [CW-1:0]        r_drop_cnt;
    logic [CW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_rd_ptr;
    logic [ADDR_W-1:0]    r_pc_mem    [DEPTH];
    logic [31:0]          r_instr_mem [DEPTH];

    logic [CW-1:0]        w_occ;
    logic [CW:0]          w_sum_ol;
    logic [CW:0]          w_sum_ld;
    logic                 w_req_vld;
    logic                 w_req_fire;
    logic                 w_keep;
    logic                 w_drop;
    logic                 w_pop;
    logic [CW-1:0]        w_inflight;
    logic [CW-1:0]        w_redir_drop;
    logic [ADDR_W-1:0]    w_redirect_pc;

    // Low two bits of the redirect target are masked so fetches stay word aligned.
    assign w_redirect_pc = redirect_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};

    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_sum_ol   = {1'b0, w_occ} + {1'b0, r_live_cnt};
    assign w_sum_ld   = {1'b0, r_live_cnt} + {1'b0, r_drop_cnt};
    // A request needs both a FIFO slot for its data and a tracking slot in the in-flight counters.
    assign w_req_vld  = !r_clr_q && !redirect && (w_sum_ol < DEPTH_W) && (w_sum_ld < DEPTH_W);
    assign w_req_fire = w_req_vld && imem_req_ready;
    // Stale responses are consumed first; an untracked response (protocol error) is ignored.
    assign w_drop     = imem_resp_valid && !redirect && !clr && (r_drop_cnt != '0);
    assign w_keep     = imem_resp_valid && !redirect && !clr && (r_drop_cnt == '0) && (r_live_cnt != '0);
    assign w_pop      = (w_occ != '0) && out_ready && !redirect;

    // Every outstanding request becomes stale on redirect; a response landing this cycle consumes one of them.
    assign w_inflight   = r_drop_cnt + r_live_cnt;
    assign w_redir_drop = (imem_resp_valid && (w_inflight != '0)) ? (w_inflight - CW'(1)) : w_inflight;

    assign imem_req_valid = w_req_vld;
    assign imem_req_addr  = r_fetch_pc;
    assign out_valid      = (w_occ != '0);
    assign out_pc         = r_pc_mem[r_rd_ptr[AW-1:0]];
    assign out_instr      = r_instr_mem[r_rd_ptr[AW-1:0]];
    assign occupancy      = w_occ;

    // Control state: fetch PC, response PC, credit counters and FIFO pointers; redirect overrides all but clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_clr_q    <= 1'b1;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_clr_q <= 1'b0;
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_live_cnt <= '0;
                r_drop_cnt <= w_redir_drop;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                end
                r_live_cnt <= r_live_cnt + CW'(w_req_fire) - CW'(w_keep);
                r_drop_cnt <= r_drop_cnt - CW'(w_drop);
                if (w_keep) begin
                    r_wr_ptr  <= r_wr_ptr + CW'(1);
                    r_resp_pc <= r_resp_pc + ADDR_W'(4);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + CW'(1);
                end
            end
        end
    end

    // Entry storage: kept responses are tagged with the PC of the oldest live request.
    always_ff @(posedge clk) begin
        if (w_keep) begin
            r_pc_mem[r_wr_ptr[AW-1:0]]    <= r_resp_pc;
            r_instr_mem[r_wr_ptr[AW-1:0]] <= imem_resp_data;
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (clr)
        imem_resp_valid |-> ((r_live_cnt != '0) || (r_drop_cnt != '0)));

    a_cnt_bound: assert property (@(posedge clk) disable iff (clr)
        (w_sum_ol <= DEPTH_W) && (w_sum_ld <= DEPTH_W));

    a_req_hold: assert property (@(posedge clk) disable iff (clr)
        (imem_req_valid && !imem_req_ready) |=> (imem_req_valid || redirect || r_clr_q));

endmodule
